// File: rtl/upgrade_pkg.sv
// Shared types and defaults for the upgrade pickup spawner.
package upgrade_pkg;

  typedef enum logic [2:0] {
    ST_COOLDOWN,
    ST_SPAWN,
    ST_ACTIVE,
    ST_HELD1,
    ST_HELD2
  } upg_state_t;

  // Fibonacci feedback taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int          DEF_SPAWN_DELAY = 300;
  localparam int          DEF_HOLD_FRAMES = 600;
  localparam int          DEF_UPG_SIZE    = 4;
  localparam int          DEF_X_MIN       = 32;
  localparam int          DEF_Y_MIN       = 32;
  localparam logic [15:0] DEF_LFSR_SEED   = 16'hACE1;

endpackage

// File: rtl/upgrade_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the spawn position source.
module upgrade_lfsr
  import upgrade_pkg::*;
(
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  // Advance once per frame regardless of game state
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) value <= seed;
    else       value <= {value[14:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/upgrade_spawner.sv
// Upgrade pickup spawner: cooldown, random spawn, collection and grant.
// Optional build macro UPGRADE_EXPIRE_EN: grants expire after HOLD_FRAMES
// frames and the spawner returns to COOLDOWN; otherwise grants are held
// until Reset.
module upgrade_spawner
  import upgrade_pkg::*;
#(
  parameter int          SPAWN_DELAY = DEF_SPAWN_DELAY,
  parameter int          HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int          UPG_SIZE    = DEF_UPG_SIZE,
  parameter int          X_MIN       = DEF_X_MIN,
  parameter int          Y_MIN       = DEF_Y_MIN,
  parameter logic [15:0] LFSR_SEED   = DEF_LFSR_SEED
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       game_active,
  input  logic       collect_1,
  input  logic       collect_2,
  output logic [9:0] UpgradeX,
  output logic [9:0] UpgradeY,
  output logic [9:0] Upgrade_Size,
  output logic       upgrade_visible,
  output logic       bullet_1_upgraded,
  output logic       bullet_2_upgraded,
  output logic       rearm
);

  localparam logic [15:0] SPAWN_LAST = 16'(SPAWN_DELAY - 1);

  // Parameter sanity: window must stay on screen, seed must be nonzero
  if (SPAWN_DELAY < 1 || HOLD_FRAMES < 1 || LFSR_SEED == 16'h0000 ||
      X_MIN + 511 > 639 || Y_MIN + 255 > 479) begin : g_bad_params
    $error("upgrade_spawner: illegal parameter set");
  end

  upg_state_t  state, state_nxt;
  logic [15:0] count, count_nxt;
  logic [15:0] lfsr_val;

  upgrade_lfsr u_lfsr (
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .seed      (LFSR_SEED),
    .value     (lfsr_val)
  );

  assign Upgrade_Size = 10'(UPG_SIZE);

  // State and frame counter register
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_COOLDOWN;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state logic; SPAWN always completes, everything else freezes
  // while the game is paused
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (state == ST_SPAWN) begin
      state_nxt = ST_ACTIVE;
    end else if (game_active) begin
      case (state)
        ST_COOLDOWN: begin
          if (count == SPAWN_LAST) begin
            state_nxt = ST_SPAWN;
            count_nxt = '0;
          end else begin
            count_nxt = count + 16'd1;
          end
        end
        ST_ACTIVE: begin
          if (collect_1)      state_nxt = ST_HELD1;
          else if (collect_2) state_nxt = ST_HELD2;
        end
        ST_HELD1, ST_HELD2: begin
`ifdef UPGRADE_EXPIRE_EN
          if (count == 16'(HOLD_FRAMES - 1)) begin
            state_nxt = ST_COOLDOWN;
            count_nxt = '0;
          end else begin
            count_nxt = count + 16'd1;
          end
`else
          state_nxt = state;
`endif
        end
        default: begin
          state_nxt = ST_COOLDOWN;
          count_nxt = '0;
        end
      endcase
    end
  end

  // Registered outputs, one frame behind state entry; position holds
  // between spawns
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      UpgradeX          <= 10'(X_MIN);
      UpgradeY          <= 10'(Y_MIN);
      upgrade_visible   <= 1'b0;
      bullet_1_upgraded <= 1'b0;
      bullet_2_upgraded <= 1'b0;
      rearm             <= 1'b0;
    end else begin
      upgrade_visible   <= (state == ST_ACTIVE);
      bullet_1_upgraded <= (state == ST_HELD1);
      bullet_2_upgraded <= (state == ST_HELD2);
      rearm             <= (state == ST_SPAWN);
      if (state == ST_SPAWN) begin
        UpgradeX <= 10'(X_MIN) + {1'b0, lfsr_val[8:0]};
        UpgradeY <= 10'(Y_MIN) + {2'b00, lfsr_val[15:8]};
      end
    end
  end

endmodule

// File: tb/tb_upgrade_spawner.sv
// Directed bench for upgrade_spawner (SPAWN_DELAY=4, HOLD_FRAMES=3).
module tb_upgrade_spawner;

  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       game_active = 1'b0;
  logic       collect_1 = 1'b0;
  logic       collect_2 = 1'b0;
  logic [9:0] UpgradeX, UpgradeY, Upgrade_Size;
  logic       upgrade_visible, bullet_1_upgraded, bullet_2_upgraded, rearm;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] m_lfsr, m_prev;

  upgrade_spawner #(
    .SPAWN_DELAY (4),
    .HOLD_FRAMES (3),
    .UPG_SIZE    (4),
    .X_MIN       (32),
    .Y_MIN       (32),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .Reset             (Reset),
    .frame_clk         (frame_clk),
    .game_active       (game_active),
    .collect_1         (collect_1),
    .collect_2         (collect_2),
    .UpgradeX          (UpgradeX),
    .UpgradeY          (UpgradeY),
    .Upgrade_Size      (Upgrade_Size),
    .upgrade_visible   (upgrade_visible),
    .bullet_1_upgraded (bullet_1_upgraded),
    .bullet_2_upgraded (bullet_2_upgraded),
    .rearm             (rearm)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR; m_prev is the value the DUT saw at the latest edge
  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    collect_1 = 1'b0;
    collect_2 = 1'b0;
    game_active = 1'b1;
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #1;
    n_total++;
    if ({UpgradeX, UpgradeY} !== {10'd32, 10'd32})
      $display("FAIL reset_pos got %0d,%0d want 32,32", UpgradeX, UpgradeY);
    else n_pass++;
    n_total++;
    if ({upgrade_visible, bullet_1_upgraded, bullet_2_upgraded, rearm} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000",
               {upgrade_visible, bullet_1_upgraded, bullet_2_upgraded, rearm});
    else n_pass++;
    n_total++;
    if (Upgrade_Size !== 10'd4) $display("FAIL upg_size got %0d want 4", Upgrade_Size);
    else n_pass++;
    do_reset();
  endtask

  // Frames 1..4 quiet, rearm in frame 5 with hand-computed position,
  // visible from frame 6
  task automatic test_first_spawn();
    for (int f = 1; f <= 4; f++) begin
      step();
      n_total++;
      if ({rearm, upgrade_visible} !== 2'b00)
        $display("FAIL cooldown_quiet frame %0d got rearm=%b vis=%b want 0,0", f, rearm, upgrade_visible);
      else n_pass++;
    end
    step();
    n_total++;
    if ({rearm, upgrade_visible} !== 2'b10)
      $display("FAIL spawn_rearm got rearm=%b vis=%b want 1,0", rearm, upgrade_visible);
    else n_pass++;
    n_total++;
    if ({UpgradeX, UpgradeY} !== {10'd62, 10'd238})
      $display("FAIL spawn_pos got %0d,%0d want 62,238", UpgradeX, UpgradeY);
    else n_pass++;
    step();
    n_total++;
    if ({rearm, upgrade_visible} !== 2'b01)
      $display("FAIL active_vis got rearm=%b vis=%b want 0,1", rearm, upgrade_visible);
    else n_pass++;
    n_total++;
    if (UpgradeX < 10'd32 || UpgradeX > 10'd543 || UpgradeY < 10'd32 || UpgradeY > 10'd287)
      $display("FAIL pos_range got %0d,%0d want within [32,543]x[32,287]", UpgradeX, UpgradeY);
    else n_pass++;
  endtask

  // Both collects in the same ACTIVE frame: player 1 wins
  task automatic test_simultaneous();
    collect_1 = 1'b1;
    collect_2 = 1'b1;
    step();
    collect_1 = 1'b0;
    step();
    n_total++;
    if ({bullet_1_upgraded, bullet_2_upgraded, upgrade_visible} !== 3'b100)
      $display("FAIL tie_p1 got b1=%b b2=%b vis=%b want 1,0,0",
               bullet_1_upgraded, bullet_2_upgraded, upgrade_visible);
    else n_pass++;
  endtask

  // collect_2 held during HELD1 changes nothing
  task automatic test_ignore_held();
    collect_2 = 1'b1;
    for (int f = 0; f < 5; f++) begin
      step();
      n_total++;
      if ({bullet_1_upgraded, bullet_2_upgraded, upgrade_visible, rearm} !== 4'b1000)
        $display("FAIL held1_ignore frame %0d got %b want 1000", f,
                 {bullet_1_upgraded, bullet_2_upgraded, upgrade_visible, rearm});
      else n_pass++;
    end
    collect_2 = 1'b0;
  endtask

  // Reset mid-frame in HELD1 clears everything without a clock edge
  task automatic test_reset_in_held();
    #2;
    Reset = 1'b1;
    #1;
    n_total++;
    if ({bullet_1_upgraded, bullet_2_upgraded, upgrade_visible, rearm} !== 4'b0000 ||
        {UpgradeX, UpgradeY} !== {10'd32, 10'd32})
      $display("FAIL async_reset got flags=%b pos=%0d,%0d want 0000 32,32",
               {bullet_1_upgraded, bullet_2_upgraded, upgrade_visible, rearm}, UpgradeX, UpgradeY);
    else n_pass++;
    do_reset();
  endtask

  // collect_2 during COOLDOWN ignored; then collect_2 alone grants player 2
  task automatic test_ignore_cooldown();
    collect_2 = 1'b1;
    for (int f = 1; f <= 4; f++) begin
      step();
      if (f == 4) collect_2 = 1'b0;
      n_total++;
      if ({rearm, upgrade_visible, bullet_2_upgraded} !== 3'b000)
        $display("FAIL cooldown_ignore frame %0d got %b want 000", f,
                 {rearm, upgrade_visible, bullet_2_upgraded});
      else n_pass++;
    end
    step();
    n_total++;
    if (rearm !== 1'b1) $display("FAIL cooldown_timing got rearm=%b want 1", rearm);
    else n_pass++;
    step();
    collect_2 = 1'b1;
    step();
    collect_2 = 1'b0;
    step();
    n_total++;
    if ({bullet_1_upgraded, bullet_2_upgraded, upgrade_visible} !== 3'b010)
      $display("FAIL grant_p2 got b1=%b b2=%b vis=%b want 0,1,0",
               bullet_1_upgraded, bullet_2_upgraded, upgrade_visible);
    else n_pass++;
  endtask

`ifdef UPGRADE_EXPIRE_EN
  // Grant lasts exactly HOLD_FRAMES frames, then respawn after SPAWN_DELAY
  task automatic test_hold_end();
    int hi = 1;
    int f;
    for (f = 0; f < 10 && bullet_2_upgraded === 1'b1; f++) begin
      step();
      if (bullet_2_upgraded === 1'b1) hi++;
    end
    n_total++;
    if (hi !== 3) $display("FAIL expire_len got %0d frames want 3", hi);
    else n_pass++;
    for (f = 0; f < 30 && rearm !== 1'b1; f++) step();
    n_total++;
    if (f !== 4) $display("FAIL expire_respawn got rearm %0d frames after drop want 4", f);
    else n_pass++;
  endtask
`else
  // Grant is terminal: no drop and no respawn
  task automatic test_hold_end();
    for (int f = 0; f < 20; f++) begin
      step();
      n_total++;
      if ({bullet_2_upgraded, rearm, upgrade_visible} !== 3'b100)
        $display("FAIL held_terminal frame %0d got %b want 100", f,
                 {bullet_2_upgraded, rearm, upgrade_visible});
      else n_pass++;
    end
  endtask
`endif

  // Pause for 10 frames in COOLDOWN delays spawn by 10; pause in ACTIVE
  // blocks collection
  task automatic test_freeze();
    int first = 0;
    do_reset();
    for (int f = 1; f <= 40; f++) begin
      step();
      if (f == 2)  game_active = 1'b0;
      if (f == 12) game_active = 1'b1;
      if (rearm === 1'b1) begin
        first = f;
        break;
      end
    end
    n_total++;
    if (first !== 15) $display("FAIL freeze_delay got rearm frame %0d want 15", first);
    else n_pass++;
    n_total++;
    if ({UpgradeX, UpgradeY} !== {10'd32 + {1'b0, m_prev[8:0]}, 10'd32 + {2'b00, m_prev[15:8]}})
      $display("FAIL freeze_pos got %0d,%0d want %0d,%0d", UpgradeX, UpgradeY,
               10'd32 + {1'b0, m_prev[8:0]}, 10'd32 + {2'b00, m_prev[15:8]});
    else n_pass++;
    step();
    game_active = 1'b0;
    collect_1 = 1'b1;
    for (int f = 0; f < 3; f++) begin
      step();
      n_total++;
      if ({upgrade_visible, bullet_1_upgraded} !== 2'b10)
        $display("FAIL freeze_active frame %0d got vis=%b b1=%b want 1,0", f,
                 upgrade_visible, bullet_1_upgraded);
      else n_pass++;
    end
    game_active = 1'b1;
    step();
    collect_1 = 1'b0;
    step();
    n_total++;
    if ({upgrade_visible, bullet_1_upgraded} !== 2'b01)
      $display("FAIL resume_grant got vis=%b b1=%b want 0,1", upgrade_visible, bullet_1_upgraded);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_simultaneous();
    test_ignore_held();
    test_reset_in_held();
    test_ignore_cooldown();
    test_hold_end();
    test_freeze();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
